// File: rtl/mips_pkg.sv
// Shared types and opcode constants for the MIPS decode / operand-fetch stage.
package mips_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef logic [11:0] ctrl_t;
    typedef logic [4:0]  reg_addr_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} stage_state_e;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] src1;
        logic [31:0] src2;
        reg_addr_t   dst;
        logic        wen;
    } idex_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports, one write port, R0 hardwired to zero.
// Define WB_BYPASS_EN to forward same-cycle write data onto the read ports.
module reg_file
    import mips_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  reg_addr_t       raddr1_i,
    input  reg_addr_t       raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  reg_addr_t       waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
        rdata2_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
`ifdef WB_BYPASS_EN
        // waddr_i != 0 also guarantees the R0 reads stay zero
        if (we_i && (waddr_i != '0) && (waddr_i == raddr1_i)) rdata1_o = wdata_i;
        if (we_i && (waddr_i != '0) && (waddr_i == raddr2_i)) rdata2_o = wdata_i;
`endif
    end

endmodule

// File: rtl/id_ex_stage.sv
// MIPS decode / operand-fetch stage feeding the ALU through a one-entry ID/EX register.
// Build option WB_BYPASS_EN: same-cycle write-back data is forwarded to operand reads.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            flush,
    input  logic            wb_en,
    input  reg_addr_t       wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output ctrl_t           out_ctrl,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output reg_addr_t       out_dst,
    output logic            out_wen
);

    logic [5:0]      op;
    logic [5:0]      funct;
    reg_addr_t       rs, rt, rd;
    logic [15:0]     imm;
    logic [XLEN-1:0] rs_data, rt_data;
    logic            accept;
    logic            dec_known;
    idex_t           idex_d, idex_q;
    stage_state_e    state_q;

    assign op    = in_instr[31:26];
    assign rs    = in_instr[25:21];
    assign rt    = in_instr[20:16];
    assign rd    = in_instr[15:11];
    assign funct = in_instr[5:0];
    assign imm   = in_instr[15:0];

    reg_file #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .raddr1_i (rs),
        .raddr2_i (rt),
        .rdata1_o (rs_data),
        .rdata2_o (rt_data),
        .we_i     (wb_en),
        .waddr_i  (wb_addr),
        .wdata_i  (wb_data)
    );

    always_comb begin
        dec_known   = 1'b1;
        idex_d      = '0;
        idex_d.ctrl = {op, 6'h00};
        idex_d.src1 = rs_data;
        idex_d.src2 = sign_ext16(imm);
        idex_d.dst  = rt;
        unique case (op)
            OP_RTYPE: begin
                idex_d.ctrl = {op, funct};
                idex_d.src2 = rt_data;
                idex_d.dst  = rd;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: ;
            OP_ANDI, OP_ORI, OP_XORI: idex_d.src2 = {16'h0000, imm};
            OP_LUI: begin
                idex_d.src1 = '0;
                idex_d.src2 = {imm, 16'h0000};
            end
            default: dec_known = 1'b0;
        endcase
        idex_d.wen = dec_known && (idex_d.dst != '0);
    end

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !flush;

    // Data is captured only on accept, so a stall or drain leaves out_* untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            idex_q  <= '0;
        end else if (flush) begin
            state_q <= ST_EMPTY;
        end else if (accept) begin
            state_q <= ST_FULL;
            idex_q  <= idex_d;
        end else if (out_ready) begin
            state_q <= ST_EMPTY;
        end
    end

    assign out_ctrl = idex_q.ctrl;
    assign out_src1 = idex_q.src1;
    assign out_src2 = idex_q.src2;
    assign out_dst  = idex_q.dst;
    assign out_wen  = idex_q.wen;

endmodule
